// File: rtl/dffram_pipe_if.sv
// Host-side bus of the flop RAM: request (EN/WE/A/Di) and response/status (Do/Do_valid/BUSY).
// Parameters must match those of the dffram_pipe instance the bus is bound to.
interface dffram_pipe_if #(
    parameter int BYTES = 4,
    parameter int COLS  = 1
);
    localparam int DW = 8 * BYTES;
    localparam int AW = 8 + $clog2(COLS);

    logic             EN;
    logic [BYTES-1:0] WE;
    logic [AW-1:0]    A;
    logic [DW-1:0]    Di;
    logic [DW-1:0]    Do;
    logic             Do_valid;
    logic             BUSY;

    modport master (
        output EN, WE, A, Di,
        input  Do, Do_valid, BUSY
    );

    modport slave (
        input  EN, WE, A, Di,
        output Do, Do_valid, BUSY
    );
endinterface

// File: rtl/dffram_pipe.sv
// Parametrised single-port flop RAM with byte-lane writes, optional output register,
// post-reset hardware clear sequencer, BUSY indication and read-data valid strobe.
module dffram_pipe #(
    parameter int BYTES          = 4,
    parameter int COLS           = 1,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           CLK,
    input  logic           RST,
    dffram_pipe_if.slave   bus
);
    localparam int DW    = 8 * BYTES;
    localparam int DEPTH = 256 * COLS;
    localparam int AW    = 8 + $clog2(COLS);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t ST_AFTER_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic            r_busy;
    logic [DW-1:0]   r_mem [0:DEPTH-1];
    logic [DW-1:0]   r_do;
    logic            r_do_valid;
    logic            w_rd_req;
    logic            w_wr_req;
    logic [DW-1:0]   w_rd_data;

    // Host requests only count once the clear sequence has handed the array over.
    assign w_rd_req  = (r_state == ST_READY) && bus.EN && (bus.WE == {BYTES{1'b0}});
    assign w_wr_req  = (r_state == ST_READY) && bus.EN && (bus.WE != {BYTES{1'b0}});
    assign w_rd_data = r_mem[bus.A];

    // Next-state logic: leave CLEAR in the cycle after the last word has been zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_READY;
        endcase
    end

    // State, clear counter and BUSY flag; reset restarts the clear from address 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_AFTER_RST;
            r_clr_cnt <= {AW{1'b0}};
            r_busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + AW'(1);
            end
        end
    end

    // Array write port: the sequencer owns it while clearing, then byte-masked host writes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= {DW{1'b0}};
            end else if (w_wr_req) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (bus.WE[i]) begin
                        r_mem[bus.A][8*i +: 8] <= bus.Di[8*i +: 8];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] r_stage_data;
            logic          r_stage_vld;

            // Two-stage read path; the stage valid is dropped on reset so in-flight reads vanish.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_stage_data <= {DW{1'b0}};
                    r_stage_vld  <= 1'b0;
                    r_do         <= {DW{1'b0}};
                    r_do_valid   <= 1'b0;
                end else begin
                    r_stage_vld <= w_rd_req;
                    if (w_rd_req) begin
                        r_stage_data <= w_rd_data;
                    end
                    r_do_valid <= r_stage_vld;
                    if (r_stage_vld) begin
                        r_do <= r_stage_data;
                    end
                end
            end
        end else begin : g_direct
            // Single-stage read path; Do holds its last read value while idle.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_do       <= {DW{1'b0}};
                    r_do_valid <= 1'b0;
                end else begin
                    r_do_valid <= w_rd_req;
                    if (w_rd_req) begin
                        r_do <= w_rd_data;
                    end
                end
            end
        end
    endgenerate

    assign bus.Do       = r_do;
    assign bus.Do_valid = r_do_valid;
    assign bus.BUSY     = r_busy;

endmodule

// File: tb/tb_dffram_pipe.sv
// Scoreboard bench for dffram_pipe: three instances (default, OUT_REG=1, 16-bit/1K-word no-clear).
// Stimulus pushes expected read data; per-instance monitors pop and compare on Do_valid.
module tb_dffram_pipe;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    dffram_pipe_if #(.BYTES(4), .COLS(1)) bus0 ();
    dffram_pipe_if #(.BYTES(4), .COLS(1)) bus1 ();
    dffram_pipe_if #(.BYTES(2), .COLS(4)) bus2 ();

    dffram_pipe #(.BYTES(4), .COLS(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
        .CLK(clk), .RST(rst0), .bus(bus0)
    );
    dffram_pipe #(.BYTES(4), .COLS(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u1 (
        .CLK(clk), .RST(rst1), .bus(bus1)
    );
    dffram_pipe #(.BYTES(2), .COLS(4), .OUT_REG(0), .CLEAR_ON_RESET(0)) u2 (
        .CLK(clk), .RST(rst2), .bus(bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare data and latency whenever a DUT presents Do_valid.
    always @(negedge clk) begin
        if (bus0.Do_valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("u0 unexpected Do_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("u0 read data", bus0.Do, e.data);
                check("u0 read latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.Do_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("u1 unexpected Do_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("u1 read data", bus1.Do, e.data);
                check("u1 read latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.Do_valid === 1'b1) begin
            if (q2.size() == 0) begin
                check("u2 unexpected Do_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("u2 read data", {16'h0000, bus2.Do}, e.data);
                check("u2 read latency", cyc - e.cyc, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic en, input logic [3:0] we,
                         input logic [9:0] a, input logic [31:0] di);
        case (d)
            0: begin bus0.EN = en; bus0.WE = we; bus0.A = a[7:0]; bus0.Di = di; end
            1: begin bus1.EN = en; bus1.WE = we; bus1.A = a[7:0]; bus1.Di = di; end
            default: begin bus2.EN = en; bus2.WE = we[1:0]; bus2.A = a; bus2.Di = di[15:0]; end
        endcase
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, 4'h0, 10'h000, 32'h0);
    endtask

    task automatic wr(input int d, input logic [3:0] we, input logic [9:0] a, input logic [31:0] di);
        drive(d, 1'b1, we, a, di);
        tick();
    endtask

    task automatic rd(input int d, input logic [9:0] a, input logic [31:0] expv);
        exp_t e;
        e.data = expv;
        e.cyc  = cyc;
        drive(d, 1'b1, 4'h0, a, 32'h0);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        tick();
    endtask

    // Counts BUSY-high negedges for u0; stops driving the ignored clear-time write at 200.
    task automatic count_busy0(output int cnt, input logic stop_drive);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus0.BUSY === 1'b1) begin
                cnt++;
                if (stop_drive && cnt == 200) idle(0);
            end else begin
                break;
            end
        end
    endtask

    initial begin
        int cnt;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        idle(0); idle(1); idle(2);
        repeat (2) tick();

        check("u0 reset Do", bus0.Do, 32'h0);
        check("u0 reset Do_valid", {31'd0, bus0.Do_valid}, 32'd0);
        check("u0 reset BUSY", {31'd0, bus0.BUSY}, 32'd1);
        check("u1 reset Do", bus1.Do, 32'h0);
        check("u2 reset BUSY", {31'd0, bus2.BUSY}, 32'd0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // Requests during CLEAR must be ignored.
        drive(0, 1'b1, 4'hF, 10'h020, 32'hFFFF_FFFF);
        count_busy0(cnt, 1'b1);
        check("u0 BUSY cycles after reset", cnt, 32'd256);
        check("u1 BUSY low after clear", {31'd0, bus1.BUSY}, 32'd0);

        rd(0, 10'h000, 32'h0);
        rd(0, 10'h07F, 32'h0);
        rd(0, 10'h0FF, 32'h0);
        rd(0, 10'h020, 32'h0);

        // Byte lanes and write-then-read collision.
        wr(0, 4'hF, 10'h010, 32'hAABB_CCDD);
        wr(0, 4'b0101, 10'h010, 32'h1122_3344);
        rd(0, 10'h010, 32'hAA22_CC44);
        wr(0, 4'b1010, 10'h010, 32'h9988_7766);
        rd(0, 10'h010, 32'h9922_7744);
        idle(0);
        tick();
        check("u0 idle Do_valid", {31'd0, bus0.Do_valid}, 32'd0);
        check("u0 idle Do hold", bus0.Do, 32'h9922_7744);

        // OUT_REG=1 streaming latency.
        wr(1, 4'hF, 10'h001, 32'h1);
        wr(1, 4'hF, 10'h002, 32'h2);
        wr(1, 4'hF, 10'h003, 32'h3);
        rd(1, 10'h001, 32'h1);
        rd(1, 10'h002, 32'h2);
        rd(1, 10'h003, 32'h3);
        idle(1);
        tick();
        tick();
        check("u1 idle Do_valid", {31'd0, bus1.Do_valid}, 32'd0);
        check("u1 idle Do hold", bus1.Do, 32'h3);

        // Reset the cycle after a read with OUT_REG=1: the read is dropped.
        wr(1, 4'hF, 10'h005, 32'h1234_5678);
        drive(1, 1'b1, 4'h0, 10'h005, 32'h0);
        tick();
        idle(1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("u1 dropped read Do", bus1.Do, 32'h0);
        check("u1 dropped read Do_valid", {31'd0, bus1.Do_valid}, 32'd0);
        repeat (3) begin
            tick();
            check("u1 no late Do_valid", {31'd0, bus1.Do_valid}, 32'd0);
        end

        // Reset at clear counter 100 restarts a full clear.
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (100) tick();
        check("u0 BUSY mid-clear", {31'd0, bus0.BUSY}, 32'd1);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        count_busy0(cnt, 1'b0);
        check("u0 BUSY cycles after mid-clear reset", cnt, 32'd256);
        rd(0, 10'h010, 32'h0);
        rd(0, 10'h020, 32'h0);
        idle(0);

        // 16-bit, 1K-word instance without clear.
        wr(2, 4'h3, 10'h3FF, 32'hBEEF);
        rd(2, 10'h3FF, 32'hBEEF);
        wr(2, 4'h3, 10'h200, 32'h1111);
        wr(2, 4'h3, 10'h000, 32'hA5A5);
        wr(2, 4'h2, 10'h000, 32'h3C00);
        rd(2, 10'h000, 32'h3CA5);
        rd(2, 10'h200, 32'h1111);
        rd(2, 10'h3FF, 32'hBEEF);
        idle(2);

        for (int i = 0; i < 10; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
            tick();
        end
        check("u0 scoreboard drained", q0.size(), 32'd0);
        check("u1 scoreboard drained", q1.size(), 32'd0);
        check("u2 scoreboard drained", q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dffram_pipe.md
Name: dffram_pipe

Overview:
- Parametrised single-port flop-based RAM that succeeds the fixed 32-bit DFFRAM macro.
- Word width, byte-lane count, depth and read pipeline depth are all configurable.
- Adds a post-reset hardware clear sequencer, a BUSY indication, and a read-data valid strobe.
- Sits behind the SoC memory-bus adapter as scratch/data RAM. The adapter must stall while BUSY=1.

Parameters:
- BYTES, 4, number of byte lanes; word width DW = 8*BYTES (legal range 1..8)
- COLS, 1, depth multiplier; DEPTH = 256*COLS words, COLS a power of two (1..8)
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = no clear, ready immediately

Ports:
- CLK  input  1  clock; all logic on the rising edge
- RST  input  1  synchronous, active-high reset
- EN  input  1  access request, sampled on CLK
- WE  input  BYTES  per-byte write enable; WE!=0 with EN=1 is a write, otherwise a read
- A  input  8+$clog2(COLS)  word address
- Di  input  DW  write data; lane i = Di[8i+7:8i]
- Do  output  DW  read data
- Do_valid  output  1  one-cycle strobe marking Do as fresh read data
- BUSY  output  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset (RST=1 on an edge):
  - Do=0, Do_valid=0, all pipeline valid flags cleared.
  - Next state is CLEAR if CLEAR_ON_RESET=1, else READY.
  - BUSY=1 in the cycle after reset when clearing; BUSY=0 when not.
  - Reset dominates every other input, including mid-clear and mid-read.
- States:
  - CLEAR: counter starts at 0. Each cycle writes all-zero to RAM[counter] and increments the counter. The transition to READY happens in the cycle after address DEPTH-1 is written. BUSY=1 for exactly DEPTH cycles. EN/WE/A/Di are ignored and Do_valid stays 0.
  - READY: BUSY=0. Serves one access per cycle with no back-pressure.
- Write (EN=1, WE!=0):
  - Only lanes with WE[i]=1 are updated; other lanes keep their value.
  - No Do_valid is produced for a write.
- Read (EN=1, WE=0):
  - OUT_REG=0: Do=RAM[A] and Do_valid=1 on the next edge.
  - OUT_REG=1: data is captured into a stage register, then presented on Do with Do_valid=1 one edge later.
  - Back-to-back reads stream at one per cycle with constant latency.
- Read/write collision: a write followed by a read of the same address in the next cycle returns the new data (no bypass needed, since the array is already updated).
- Idle/hold: EN=0 leaves Do holding its last read value and drives Do_valid=0.
  - This intentionally differs from the predecessor, which zeroed Do.
- Address width is exactly log2(DEPTH), so out-of-range access is impossible.
- Reset during CLEAR restarts the clear at address 0.
- Reset with a read in flight drops that read: no Do_valid ever appears for it.
- Memory contents are not reset by RST itself; they are zeroed only by CLEAR.

Test Plan:
- Reset clear, default params: pulse RST for 1 cycle -> BUSY=1 for exactly 256 cycles, then 0. Reads of A=0x00, 0x7F and 0xFF each return 0x00000000 with Do_valid one cycle later.
- Byte lanes, BYTES=4: write A=0x10, Di=0xAABBCCDD, WE=4'hF; then Di=0x11223344, WE=4'b0101 -> read of 0x10 returns 0xAA22CC44.
- Latency with OUT_REG=1: reads of 0x01, 0x02, 0x03 on consecutive cycles (holding 0x1, 0x2, 0x3) -> Do_valid high on cycles 2, 3, 4 with Do = 0x1, 0x2, 0x3. Do_valid low on cycle 5; Do holds 0x3.
- Requests during CLEAR: assert EN=1, WE=4'hF, A=0x20, Di=0xFFFFFFFF while BUSY=1 -> after BUSY falls, a read of 0x20 returns 0x00000000.
- Reset mid-operation: assert RST at clear counter 100 -> BUSY stays 1 for a full 256 further cycles. Assert RST the cycle after a read with OUT_REG=1 -> no Do_valid pulse, Do=0.
- Generics: BYTES=2, COLS=4, CLEAR_ON_RESET=0 -> BUSY=0 right after reset. Write 0xBEEF at A=0x3FF, read back 0xBEEF; A width is 10 bits.
